logic_unit_pipe: RTL

Parametrised, pipelined bitwise logic unit: the successor to the single-bit structural NAND gate. Applies one of eight selectable two-operand logic functions to WIDTH-bit operands, with an optional running-accumulator mode, a valid/ready handshake on both sides, and registered reduction and popcount outputs. Sits between a stimulus source and any consumer that needs per-word logic results at one word per cycle.

---
 rtl/logic_unit_pkg.sv | 16 +
 rtl/logic_unit_pipe_if.sv | 36 +++
 rtl/logic_op.sv | 29 ++
 rtl/logic_unit_pipe.sv | 119 +++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
// Holds the function-select encoding used by the datapath, the interface and the benches.
package logic_unit_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_NAND = 3'd1;
    localparam op_t OP_OR   = 3'd2;
    localparam op_t OP_NOR  = 3'd3;
    localparam op_t OP_XOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_NOT  = 3'd6;
    localparam op_t OP_PASS = 3'd7;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Handshake and data bundle for logic_unit_pipe.
// The master side offers words and consumes results; the slave side is the unit itself.
interface logic_unit_pipe_if
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic             acc_en;
    logic             acc_clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             red_and;
    logic             red_or;
    logic             red_xor;
    logic [CW-1:0]    ones;

    modport master (
        output in_valid, op, acc_en, acc_clr, a, b, out_ready,
        input  in_ready, out_valid, c, red_and, red_or, red_xor, ones
    );

    modport slave (
        input  in_valid, op, acc_en, acc_clr, a, b, out_ready,
        output in_ready, out_valid, c, red_and, red_or, red_xor, ones
    );

endinterface

// File: rtl/logic_op.sv
// Purely combinational WIDTH-bit two-operand logic function f(op, a, b).
// b is ignored for NOT a and PASS a.
module logic_op
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can leave it unassigned and infer a latch.
        f = '0;
        case (op)
            OP_AND:  f = a & b;
            OP_NAND: f = ~(a & b);
            OP_OR:   f = a | b;
            OP_NOR:  f = ~(a | b);
            OP_XOR:  f = a ^ b;
            OP_XNOR: f = ~(a ^ b);
            OP_NOT:  f = ~a;
            OP_PASS: f = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with running accumulator, valid/ready on both sides,
// and registered reductions and popcount of the result word.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    logic_unit_pipe_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             s1_valid;
    op_t              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_c;
    logic             s2_red_and;
    logic             s2_red_or;
    logic             s2_red_xor;
    logic [CW-1:0]    s2_ones;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] s2_f;
    logic [CW-1:0]    ones_next;

    logic s1_adv;
    logic s2_adv;
    logic accept;

    // A stage may load whenever it is empty or its occupant moves on this cycle.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    logic_op #(.WIDTH(WIDTH)) u_acc_op (
        .op (bus.op),
        .a  (bus.a),
        .b  (acc),
        .f  (acc_next)
    );

    logic_op #(.WIDTH(WIDTH)) u_s2_op (
        .op (s1_op),
        .a  (s1_a),
        .b  (s1_b),
        .f  (s2_f)
    );

    // The word always carries the pre-update acc, so its result equals the new acc value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            acc <= '0;
        end else if (bus.acc_clr) begin
            acc <= '0;
        end else if (accept && bus.acc_en) begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, since the reset state of the outputs is observable.
            s1_valid <= 1'b0;
            s1_op    <= OP_AND;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_op <= bus.op;
                s1_a  <= bus.a;
                s1_b  <= bus.acc_en ? acc : bus.b;
            end
        end
    end

    always_comb begin
        ones_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_next = ones_next + CW'(s2_f[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_c       <= '0;
            s2_red_and <= 1'b0;
            s2_red_or  <= 1'b0;
            s2_red_xor <= 1'b0;
            s2_ones    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_c       <= s2_f;
                s2_red_and <= &s2_f;
                s2_red_or  <= |s2_f;
                s2_red_xor <= ^s2_f;
                s2_ones    <= ones_next;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.c         = s2_c;
    assign bus.red_and   = s2_red_and;
    assign bus.red_or    = s2_red_or;
    assign bus.red_xor   = s2_red_xor;
    assign bus.ones      = s2_ones;

endmodule
